// File: rtl/lc3_mem_sequencer.sv
// Single-port memory sequencer for the LC-3: arbitrates fetch and data requests,
// runs direct and two-phase indirect accesses, and aborts accesses that time out.
module lc3_mem_sequencer #(
    parameter int DATA_W       = 16,
    parameter int TIMEOUT      = 15,
    parameter int FETCH_STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_ind,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    // state  | meaning
    // IDLE   | no access in flight, arbitrating
    // IF_ACC | instruction fetch on the memory port
    // D_ACC  | data access, or pointer read of an indirect access
    // D_PTR  | second phase of an indirect access at the loaded pointer
    // RESP   | one-cycle ack; no grant so requesters can drop req
    typedef enum logic [2:0] {IDLE, IF_ACC, D_ACC, D_PTR, RESP} state_t;

    localparam int              SW         = $clog2(FETCH_STARVE + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(FETCH_STARVE);
    localparam logic [7:0]      WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [SW-1:0]     starve_cnt, starve_nxt;
    logic [7:0]        wait_cnt, wait_nxt;
    logic              lat_we, lat_we_nxt;
    logic              lat_ind, lat_ind_nxt;
    logic              mem_en_nxt, mem_we_nxt;
    logic [DATA_W-1:0] mem_addr_nxt, mem_wdata_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, d_rdata_nxt;
    logic              if_ack_nxt, d_ack_nxt, err_nxt;

    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        wait_nxt      = wait_cnt;
        lat_we_nxt    = lat_we;
        lat_ind_nxt   = lat_ind;
        mem_en_nxt    = mem_en;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;
        if_ack_nxt    = 1'b0;
        d_ack_nxt     = 1'b0;
        err_nxt       = 1'b0;

        unique case (state)
            IDLE: begin
                if (d_req && !(if_req && starve_cnt == STARVE_MAX)) begin
                    state_nxt     = D_ACC;
                    lat_we_nxt    = d_we;
                    lat_ind_nxt   = d_ind;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = d_we && !d_ind;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    wait_nxt      = '0;
                    if (!if_req)
                        starve_nxt = '0;
                    else if (starve_cnt != STARVE_MAX)
                        starve_nxt = starve_cnt + 1'b1;
                end else if (if_req) begin
                    state_nxt     = IF_ACC;
                    lat_we_nxt    = 1'b0;
                    lat_ind_nxt   = 1'b0;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    wait_nxt      = '0;
                    starve_nxt    = '0;
                end
            end
            IF_ACC, D_ACC, D_PTR: begin
                if (mem_ready) begin
                    if (state == D_ACC && lat_ind) begin
                        // pointer read done: reuse the port for the real access
                        state_nxt    = D_PTR;
                        mem_addr_nxt = mem_rdata;
                        mem_we_nxt   = lat_we;
                        wait_nxt     = '0;
                    end else begin
                        state_nxt  = RESP;
                        mem_en_nxt = 1'b0;
                        mem_we_nxt = 1'b0;
                        if (state == IF_ACC) begin
                            if_ack_nxt   = 1'b1;
                            if_rdata_nxt = mem_rdata;
                        end else begin
                            d_ack_nxt = 1'b1;
                            if (!lat_we)
                                d_rdata_nxt = mem_rdata;
                        end
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt  = RESP;
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    err_nxt    = 1'b1;
                    if (state == IF_ACC) begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = '0;
                    end else begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = '0;
                    end
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            lat_we     <= 1'b0;
            lat_ind    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            wait_cnt   <= wait_nxt;
            lat_we     <= lat_we_nxt;
            lat_ind    <= lat_ind_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            if_rdata   <= if_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            if_ack     <= if_ack_nxt;
            d_ack      <= d_ack_nxt;
            err        <= err_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// Bench for lc3_mem_sequencer: behavioural wait-state memory plus directed and
// randomized request scenarios checked against latency/data rules.
module tb_lc3_mem_sequencer;

    localparam int TO = 15;
    localparam int FS = 4;

    logic        clk, reset;
    logic        if_req, if_ack, d_req, d_we, d_ind, d_ack, err;
    logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, mem_ready, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    lc3_mem_sequencer #(.DATA_W(16), .TIMEOUT(TO), .FETCH_STARVE(FS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_ind(d_ind), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    typedef struct {logic [15:0] a; logic we; logic [15:0] wd;} acc_t;
    acc_t        log_q[$];
    logic [15:0] mem [int];
    int          cfg_wait = 0;
    bit          cfg_stuck = 0;
    bit          fresh = 1;
    int          waits_left = 0;
    logic [15:0] exp_d = '0;

    function automatic logic [15:0] mrd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a ^ 16'hA5A5;
    endfunction

    // memory answers #1 after each edge; ready/rdata are noise while mem_en is low
    always @(posedge clk) begin
        #1;
        if (mem_en) begin
            if (fresh) begin
                waits_left = cfg_wait;
                fresh = 0;
            end
            if (!cfg_stuck && waits_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = mrd(mem_addr);
                if (mem_we) mem[int'(mem_addr)] = mem_wdata;
                log_q.push_back('{a: mem_addr, we: mem_we, wd: mem_wdata});
                fresh = 1;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
                if (waits_left > 0) waits_left--;
            end
        end else begin
            fresh = 1;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
        end
    end

    task automatic run_req(input bit is_d, input bit we, input bit ind,
                           input logic [15:0] addr, input logic [15:0] wd, input bit drop_early,
                           output int lat, output int en_cnt, output bit got_if, output bit got_d,
                           output bit e);
        @(negedge clk);
        log_q.delete();
        if (is_d) begin
            d_req = 1; d_we = we; d_ind = ind; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1; if_addr = addr;
        end
        lat = 0; en_cnt = 0; got_if = 0; got_d = 0; e = 0;
        while (!(got_if || got_d) && lat < 64) begin
            @(negedge clk);
            lat++;
            if (mem_en) en_cnt++;
            if (if_ack || d_ack) begin
                got_if = if_ack; got_d = d_ack; e = err;
            end
            if (lat == 1) begin
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
                d_we = !we; d_ind = !ind; if_addr = 16'($urandom);
                if (drop_early) begin if_req = 0; d_req = 0; end
            end
        end
        if_req = 0; d_req = 0;
    endtask

    task automatic test_reset();
        reset = 0; if_req = 0; d_req = 0; d_we = 0; d_ind = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        #1;
        total++;
        if ({if_ack, d_ack, err, mem_en, mem_we, busy} !== 6'b0 || mem_addr !== 16'h0 ||
            mem_wdata !== 16'h0 || if_rdata !== 16'h0 || d_rdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ctl=%b addr=%h wd=%h ifr=%h dr=%h required all zero",
                     {if_ack, d_ack, err, mem_en, mem_we, busy}, mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        repeat (3) @(negedge clk);
        reset = 1;
        exp_d = '0;
    endtask

    task automatic test_fetch_zero_wait();
        int lat, en; bit gi, gd, e;
        mem[16'h3000] = 16'h1261; cfg_wait = 0; cfg_stuck = 0;
        run_req(0, 0, 0, 16'h3000, 16'h0, 0, lat, en, gi, gd, e);
        total++;
        if (lat !== 2 || en !== 1 || gi !== 1 || gd !== 0 || e !== 0) begin
            bad++;
            $display("FAIL fetch_timing: lat=%0d en=%0d ifack=%b dack=%b err=%b required 2 1 1 0 0", lat, en, gi, gd, e);
        end
        total++;
        if (if_rdata !== 16'h1261) begin
            bad++; $display("FAIL fetch_data: got %h required 1261", if_rdata);
        end
        total++;
        if (log_q.size() !== 1 || log_q[0].a !== 16'h3000 || log_q[0].we !== 1'b0) begin
            bad++; $display("FAIL fetch_port: %0d accesses, required one read of 3000", log_q.size());
        end
    endtask

    task automatic test_ldi();
        int lat, en; bit gi, gd, e;
        mem[16'h3005] = 16'h4000; mem[16'h4000] = 16'hBEEF; cfg_wait = 0;
        run_req(1, 0, 1, 16'h3005, 16'h1234, 0, lat, en, gi, gd, e);
        total++;
        if (lat !== 3 || en !== 2 || gd !== 1 || gi !== 0 || e !== 0) begin
            bad++;
            $display("FAIL ldi_timing: lat=%0d en=%0d dack=%b ifack=%b err=%b required 3 2 1 0 0", lat, en, gd, gi, e);
        end
        total++;
        if (log_q.size() !== 2 || log_q[0].a !== 16'h3005 || log_q[0].we !== 1'b0 ||
            log_q[1].a !== 16'h4000 || log_q[1].we !== 1'b0) begin
            bad++; $display("FAIL ldi_port: %0d accesses, required reads of 3005 then 4000", log_q.size());
        end
        total++;
        if (d_rdata !== 16'hBEEF) begin
            bad++; $display("FAIL ldi_data: got %h required beef", d_rdata);
        end
        exp_d = 16'hBEEF;
    endtask

    task automatic test_sti_wait();
        int lat, en; bit gi, gd, e;
        mem[16'h3010] = 16'h5000; mem[16'h5000] = 16'h7777; cfg_wait = 2;
        run_req(1, 1, 1, 16'h3010, 16'h00AA, 0, lat, en, gi, gd, e);
        total++;
        if (lat !== 7 || en !== 6 || gd !== 1 || e !== 0) begin
            bad++; $display("FAIL sti_timing: lat=%0d en=%0d dack=%b err=%b required 7 6 1 0", lat, en, gd, e);
        end
        total++;
        if (log_q.size() !== 2 || log_q[0].a !== 16'h3010 || log_q[0].we !== 1'b0 ||
            log_q[1].a !== 16'h5000 || log_q[1].we !== 1'b1 || log_q[1].wd !== 16'h00AA) begin
            bad++; $display("FAIL sti_port: %0d accesses, required read 3010 then write 00aa to 5000", log_q.size());
        end
        total++;
        if (mrd(16'h5000) !== 16'h00AA || d_rdata !== exp_d) begin
            bad++; $display("FAIL sti_result: mem=%h d_rdata=%h required 00aa %h", mrd(16'h5000), d_rdata, exp_d);
        end
    endtask

    task automatic test_timeout();
        int lat, en; bit gi, gd, e;
        cfg_stuck = 1; cfg_wait = 0;
        run_req(1, 0, 0, 16'h3020, 16'h0, 0, lat, en, gi, gd, e);
        total++;
        if (lat !== TO + 1 || en !== TO || gd !== 1 || e !== 1) begin
            bad++; $display("FAIL timeout_ld: lat=%0d en=%0d dack=%b err=%b required %0d %0d 1 1", lat, en, gd, e, TO + 1, TO);
        end
        total++;
        if (d_rdata !== 16'h0000) begin
            bad++; $display("FAIL timeout_ld_data: got %h required 0000", d_rdata);
        end
        @(negedge clk);
        total++;
        if (busy !== 0 || d_ack !== 0 || err !== 0 || mem_en !== 0) begin
            bad++; $display("FAIL timeout_idle: busy=%b dack=%b err=%b en=%b required 0", busy, d_ack, err, mem_en);
        end
        mem[16'h3030] = 16'h6000; mem[16'h6000] = 16'h1111;
        run_req(1, 1, 1, 16'h3030, 16'h2222, 0, lat, en, gi, gd, e);
        total++;
        if (lat !== TO + 1 || gd !== 1 || e !== 1 || mrd(16'h6000) !== 16'h1111 || d_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL timeout_sti: lat=%0d dack=%b err=%b mem=%h d_rdata=%h required %0d 1 1 1111 0000",
                     lat, gd, e, mrd(16'h6000), d_rdata, TO + 1);
        end
        run_req(0, 0, 0, 16'h3040, 16'h0, 0, lat, en, gi, gd, e);
        total++;
        if (gi !== 1 || e !== 1 || if_rdata !== 16'h0000) begin
            bad++; $display("FAIL timeout_fetch: ifack=%b err=%b if_rdata=%h required 1 1 0000", gi, e, if_rdata);
        end
        cfg_stuck = 0;
        exp_d = '0;
    endtask

    task automatic test_starvation();
        int kinds[$];
        int cyc = 0;
        mem[16'h3100] = 16'h0F0F; mem[16'h3200] = 16'h5A5A; cfg_wait = 0;
        @(negedge clk);
        if_req = 1; if_addr = 16'h3100;
        d_req = 1; d_we = 0; d_ind = 0; d_addr = 16'h3200;
        while (kinds.size() < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (d_ack) kinds.push_back(1);
            if (if_ack) kinds.push_back(0);
        end
        if_req = 0; d_req = 0;
        total++;
        if (kinds.size() !== 10) begin
            bad++; $display("FAIL starve_count: got %0d acks required 10", kinds.size());
        end
        for (int k = 0; k < kinds.size(); k++) begin
            total++;
            if (kinds[k] !== ((k % (FS + 1) == FS) ? 0 : 1)) begin
                bad++; $display("FAIL starve_order: ack %0d is_data=%0d required %0d", k, kinds[k],
                                (k % (FS + 1) == FS) ? 0 : 1);
            end
        end
        total++;
        if (d_rdata !== 16'h5A5A || if_rdata !== 16'h0F0F) begin
            bad++; $display("FAIL starve_data: d=%h if=%h required 5a5a 0f0f", d_rdata, if_rdata);
        end
        exp_d = 16'h5A5A;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int lat, en, w, exp_lat; bit gi, gd, e;
        int r;
        logic [15:0] addr, ptr, wd, exp_if;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 4);
            w = $urandom_range(0, 3);
            cfg_wait = w;
            addr = 16'($urandom); wd = 16'($urandom);
            ptr = 16'($urandom);
            if (ptr == addr) ptr = ptr ^ 16'h0001;
            if (r >= 3) mem[int'(addr)] = ptr;
            exp_lat = (r >= 3) ? 3 + 2 * w : 2 + w;
            exp_if = mrd(addr);
            if (r == 1) exp_d = mrd(addr);
            if (r == 3) exp_d = mrd(ptr);
            run_req(r != 0, r == 2 || r == 4, r >= 3, addr, wd, 1'($urandom_range(0, 1)),
                    lat, en, gi, gd, e);
            total++;
            if (lat !== exp_lat || gi !== (r == 0) || gd !== (r != 0) || e !== 0) begin
                bad++;
                $display("FAIL rand_handshake: op=%0d w=%0d lat=%0d ifack=%b dack=%b err=%b required lat %0d",
                         r, w, lat, gi, gd, e, exp_lat);
            end
            total++;
            if (r == 0 && if_rdata !== exp_if) begin
                bad++; $display("FAIL rand_fetch_data: got %h required %h", if_rdata, exp_if);
            end else if (r != 0 && d_rdata !== exp_d) begin
                bad++; $display("FAIL rand_d_rdata: op=%0d got %h required %h", r, d_rdata, exp_d);
            end
            if (r == 2 || r == 4) begin
                total++;
                if (mrd((r == 2) ? addr : ptr) !== wd) begin
                    bad++; $display("FAIL rand_store: op=%0d mem=%h required %h", r, mrd((r == 2) ? addr : ptr), wd);
                end
            end
            @(negedge clk);
            total++;
            if (if_ack !== 0 || d_ack !== 0 || busy !== 0) begin
                bad++; $display("FAIL rand_ack_pulse: ifack=%b dack=%b busy=%b required 0 0 0", if_ack, d_ack, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, en; bit gi, gd, e;
        bit saw_ack = 0;
        mem[16'h3300] = 16'h7000; mem[16'h7000] = 16'hC0DE; mem[16'h3400] = 16'h2468;
        cfg_wait = 2;
        @(negedge clk);
        d_req = 1; d_we = 0; d_ind = 1; d_addr = 16'h3300;
        repeat (4) @(negedge clk);
        total++;
        if (mem_en !== 1 || mem_addr !== 16'h7000 || busy !== 1) begin
            bad++; $display("FAIL reset_mid_ptr: en=%b addr=%h busy=%b required 1 7000 1", mem_en, mem_addr, busy);
        end
        @(negedge clk);
        reset = 0;
        d_req = 0;
        #1;
        total++;
        if (mem_en !== 0 || busy !== 0 || d_ack !== 0 || if_ack !== 0 || err !== 0 || d_rdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: en=%b busy=%b dack=%b ifack=%b err=%b dr=%h required all zero",
                     mem_en, busy, d_ack, if_ack, err, d_rdata);
        end
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (3) begin
            @(negedge clk);
            if (d_ack || if_ack || mem_en) saw_ack = 1;
        end
        total++;
        if (saw_ack !== 0) begin
            bad++; $display("FAIL reset_mid_silent: activity after reset, required none");
        end
        cfg_wait = 0;
        run_req(0, 0, 0, 16'h3400, 16'h0, 0, lat, en, gi, gd, e);
        total++;
        if (lat !== 2 || gi !== 1 || e !== 0 || if_rdata !== 16'h2468) begin
            bad++; $display("FAIL reset_mid_fetch: lat=%0d ifack=%b err=%b data=%h required 2 1 0 2468", lat, gi, e, if_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_ldi();
        test_sti_wait();
        test_timeout();
        test_starvation();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
